// File: rtl/hazard_bypass_unit_pkg.sv
// hazard_bypass_unit_pkg: shared tag, bypass-select and shadow-entry types
package hazard_bypass_unit_pkg;

    localparam int TAG_W = 5;

    typedef logic [TAG_W-1:0] tag_t;

    localparam tag_t REG_ZERO = '0;

    localparam logic [1:0] BYP_RF = 2'b00;
    localparam logic [1:0] BYP_M  = 2'b01;
    localparam logic [1:0] BYP_W  = 2'b10;

    // valid is the instruction-valid bit already qualified by its write enable
    typedef struct packed {
        logic valid;
        tag_t dest;
        logic is_load;
    } shadow_t;

    // X additionally remembers what its instruction reads and whether it is a mult/div;
    // live is the plain instruction-valid bit, independent of the write enable
    typedef struct packed {
        shadow_t ent;
        logic    live;
        tag_t    rs;
        tag_t    rt;
        logic    rs_used;
        logic    rt_used;
        logic    is_md;
    } x_entry_t;

endpackage

// File: rtl/hazard_bypass_unit_if.sv
// hazard_bypass_unit_if: D-stage hazard inputs and bypass/stall/multdiv outputs
interface hazard_bypass_unit_if;
    import hazard_bypass_unit_pkg::*;

    logic       d_valid;
    tag_t       d_rs;
    tag_t       d_rt;
    logic       d_rs_used;
    logic       d_rt_used;
    tag_t       d_rd;
    logic       d_writes;
    logic       d_is_load;
    logic       d_is_md;
    logic       flush;
    logic [1:0] byp_a_sel;
    logic [1:0] byp_b_sel;
    logic       stall;
    logic       md_start;
    logic       md_busy;
    logic       md_done;
    tag_t       md_dest;

    modport master (
        output d_valid, d_rs, d_rt, d_rs_used, d_rt_used, d_rd, d_writes, d_is_load, d_is_md, flush,
        input  byp_a_sel, byp_b_sel, stall, md_start, md_busy, md_done, md_dest
    );

    modport slave (
        input  d_valid, d_rs, d_rt, d_rs_used, d_rt_used, d_rd, d_writes, d_is_load, d_is_md, flush,
        output byp_a_sel, byp_b_sel, stall, md_start, md_busy, md_done, md_dest
    );

endinterface

// File: rtl/hazard_bypass_unit_reg_tag_match.sv
// reg_tag_match: register tag equality where $r0 never matches anything
module reg_tag_match
    import hazard_bypass_unit_pkg::*;
(
    input  tag_t a,
    input  tag_t b,
    output logic hit
);

    assign hit = (a == b) && (a != REG_ZERO);

endmodule

// File: rtl/hazard_bypass_unit.sv
// hazard_bypass_unit: shadow X/M/W tags, operand bypass selects, load-use and multdiv stalls
module hazard_bypass_unit
    import hazard_bypass_unit_pkg::*;
#(
    parameter int MD_LATENCY = 32,
    parameter int CNT_W      = 6
) (
    input logic              clock,
    input logic              reset,
    hazard_bypass_unit_if.slave bus
);

    x_entry_t         x_q;
    x_entry_t         x_next;
    shadow_t          m_q;
    shadow_t          w_q;
    logic [CNT_W-1:0] md_cnt;
    tag_t             md_dest_q;

    logic hit_a_m;
    logic hit_a_w;
    logic hit_b_m;
    logic hit_b_w;
    logic hit_rs_x;
    logic hit_rt_x;
    logic hit_rs_md;
    logic hit_rt_md;

    logic a_from_m;
    logic a_from_w;
    logic b_from_m;
    logic b_from_w;
    logic dep_x;
    logic dep_md;
    logic load_use;
    logic md_stall;

    reg_tag_match u_a_m  (.a(x_q.rs),     .b(m_q.dest),      .hit(hit_a_m));
    reg_tag_match u_a_w  (.a(x_q.rs),     .b(w_q.dest),      .hit(hit_a_w));
    reg_tag_match u_b_m  (.a(x_q.rt),     .b(m_q.dest),      .hit(hit_b_m));
    reg_tag_match u_b_w  (.a(x_q.rt),     .b(w_q.dest),      .hit(hit_b_w));
    reg_tag_match u_rs_x (.a(bus.d_rs),   .b(x_q.ent.dest),  .hit(hit_rs_x));
    reg_tag_match u_rt_x (.a(bus.d_rt),   .b(x_q.ent.dest),  .hit(hit_rt_x));
    reg_tag_match u_rs_md(.a(bus.d_rs),   .b(md_dest_q),     .hit(hit_rs_md));
    reg_tag_match u_rt_md(.a(bus.d_rt),   .b(md_dest_q),     .hit(hit_rt_md));

    // Bypass selects, hazard detection and multdiv status, all same-cycle from current state
    always_comb begin
        a_from_m       = x_q.rs_used & m_q.valid & hit_a_m & ~m_q.is_load;
        a_from_w       = x_q.rs_used & w_q.valid & hit_a_w;
        b_from_m       = x_q.rt_used & m_q.valid & hit_b_m & ~m_q.is_load;
        b_from_w       = x_q.rt_used & w_q.valid & hit_b_w;
        bus.byp_a_sel  = ~x_q.live ? BYP_RF : a_from_m ? BYP_M : a_from_w ? BYP_W : BYP_RF;
        bus.byp_b_sel  = ~x_q.live ? BYP_RF : b_from_m ? BYP_M : b_from_w ? BYP_W : BYP_RF;
        dep_x          = (bus.d_rs_used & hit_rs_x) | (bus.d_rt_used & hit_rt_x);
        dep_md         = (bus.d_rs_used & hit_rs_md) | (bus.d_rt_used & hit_rt_md);
        load_use       = x_q.ent.valid & x_q.ent.is_load & dep_x;
        bus.md_start   = x_q.live & x_q.is_md;
        bus.md_busy    = md_cnt != '0;
        bus.md_done    = md_cnt == CNT_W'(1);
        bus.md_dest    = md_dest_q;
        // a multdiv sitting in X has not loaded md_dest yet, so its tag is checked through X
        md_stall       = bus.d_valid & ((bus.md_busy & (bus.d_is_md | dep_md)) |
                                        (bus.md_start & (bus.d_is_md | dep_x)));
        bus.stall      = (load_use | md_stall) & ~bus.flush;
    end

    // Next X entry: D fields, turned into a bubble on stall or flush
    always_comb begin
        x_next.live        = bus.d_valid & ~bus.flush & ~bus.stall;
        x_next.ent.valid   = x_next.live & bus.d_writes;
        x_next.ent.dest    = bus.d_rd;
        x_next.ent.is_load = bus.d_is_load;
        x_next.rs          = bus.d_rs;
        x_next.rt          = bus.d_rt;
        x_next.rs_used     = bus.d_rs_used;
        x_next.rt_used     = bus.d_rt_used;
        x_next.is_md       = bus.d_is_md;
    end

    // Shadow pipeline advance; M and W always follow unconditionally
    always_ff @(posedge clock) begin
        if (!reset) begin
            x_q <= '0;
            m_q <= '0;
            w_q <= '0;
        end else begin
            x_q <= x_next;
            m_q <= x_q.ent;
            w_q <= m_q;
        end
    end

    // Multdiv occupancy counter; a flush never aborts an op already issued
    always_ff @(posedge clock) begin
        if (!reset) begin
            md_cnt    <= '0;
            md_dest_q <= REG_ZERO;
        end else if (bus.md_start) begin
            md_cnt    <= CNT_W'(MD_LATENCY);
            md_dest_q <= x_q.ent.dest;
        end else if (bus.md_busy) begin
            md_cnt    <= md_cnt - CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_bypass_unit.sv
// tb_hazard_bypass_unit: scoreboard bench driving instruction sequences through the hazard unit
module tb_hazard_bypass_unit;

    logic clock;
    logic reset;
    int   n_chk;
    int   n_pass;

    string       tags[$];
    logic [12:0] vals[$];

    hazard_bypass_unit_if bus ();

    hazard_bypass_unit #(.MD_LATENCY(4), .CNT_W(3)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [12:0] got, input logic [12:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got a,b,stall,start,busy,done,dest=%b expected %b", tag, got, exp);
    endtask

    // Scoreboard monitor: compare the oldest pending expectation against outputs mid-cycle
    always @(negedge clock) begin
        if (vals.size() != 0)
            check(tags.pop_front(),
                  {bus.byp_a_sel, bus.byp_b_sel, bus.stall, bus.md_start, bus.md_busy, bus.md_done, bus.md_dest},
                  vals.pop_front());
    end

    task automatic d_in(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic rsu, input logic rtu, input logic [4:0] rd,
                        input logic wr, input logic ld, input logic md);
        bus.d_valid   = v;
        bus.d_rs      = rs;
        bus.d_rt      = rt;
        bus.d_rs_used = rsu;
        bus.d_rt_used = rtu;
        bus.d_rd      = rd;
        bus.d_writes  = wr;
        bus.d_is_load = ld;
        bus.d_is_md   = md;
    endtask

    task automatic d_nop();
        d_in(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic step(input string tag, input logic [1:0] a, input logic [1:0] b,
                        input logic st, input logic ms, input logic mb, input logic md,
                        input logic [4:0] dst);
        tags.push_back(tag);
        vals.push_back({a, b, st, ms, mb, md, dst});
        tick();
    endtask

    task automatic drain();
        d_nop();
        bus.flush = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk      = 0;
        n_pass     = 0;
        reset      = 1'b0;
        bus.flush  = 1'b0;
        d_nop();
        tick();
        tick();
        step("reset", 2'b00, 2'b00, 0, 0, 0, 0, 5'd0);
        reset = 1'b1;
        drain();

        // back-to-back RAW through M
        d_in(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0); step("s1_c0", 2'b00, 2'b00, 0, 0, 0, 0, 5'd0);
        d_in(1, 5'd3, 5'd3, 1, 1, 5'd4, 1, 0, 0); step("s1_c1", 2'b00, 2'b00, 0, 0, 0, 0, 5'd0);
        d_nop();                                  step("m_byp", 2'b01, 2'b01, 0, 0, 0, 0, 5'd0);
        drain();

        // RAW across a nop through W, rt=$0 stays on regfile
        d_in(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0); step("s2_c0", 2'b00, 2'b00, 0, 0, 0, 0, 5'd0);
        d_nop();                                  step("s2_c1", 2'b00, 2'b00, 0, 0, 0, 0, 5'd0);
        d_in(1, 5'd3, 5'd0, 1, 1, 5'd5, 1, 0, 0); step("s2_c2", 2'b00, 2'b00, 0, 0, 0, 0, 5'd0);
        d_nop();                                  step("w_byp", 2'b10, 2'b00, 0, 0, 0, 0, 5'd0);
        drain();

        // M beats W for the same tag; unused rt never bypasses
        d_in(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0); step("pr_c0", 2'b00, 2'b00, 0, 0, 0, 0, 5'd0);
        d_in(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0); step("pr_c1", 2'b00, 2'b00, 0, 0, 0, 0, 5'd0);
        d_in(1, 5'd3, 5'd3, 1, 0, 5'd9, 1, 0, 0); step("pr_c2", 2'b00, 2'b00, 0, 0, 0, 0, 5'd0);
        d_nop();                                  step("m_prio", 2'b01, 2'b00, 0, 0, 0, 0, 5'd0);
        drain();

        // load-use: one stall cycle, then bypass from W
        d_in(1, 5'd1, 5'd0, 1, 0, 5'd2, 1, 1, 0); step("lu_c0", 2'b00, 2'b00, 0, 0, 0, 0, 5'd0);
        d_in(1, 5'd2, 5'd7, 1, 1, 5'd6, 1, 0, 0); step("lu_stall", 2'b00, 2'b00, 1, 0, 0, 0, 5'd0);
                                                  step("lu_once", 2'b00, 2'b00, 0, 0, 0, 0, 5'd0);
        d_nop();                                  step("lu_wbyp", 2'b10, 2'b00, 0, 0, 0, 0, 5'd0);
        drain();

        // $r0 never bypasses or stalls
        d_in(1, 5'd1, 5'd2, 1, 1, 5'd0, 1, 0, 0); step("r0_c0", 2'b00, 2'b00, 0, 0, 0, 0, 5'd0);
        d_in(1, 5'd0, 5'd0, 1, 1, 5'd7, 1, 0, 0); step("r0_c1", 2'b00, 2'b00, 0, 0, 0, 0, 5'd0);
        d_nop();                                  step("r0_byp", 2'b00, 2'b00, 0, 0, 0, 0, 5'd0);
        drain();
        d_in(1, 5'd1, 5'd0, 1, 0, 5'd0, 1, 1, 0); step("r0l_c0", 2'b00, 2'b00, 0, 0, 0, 0, 5'd0);
        d_in(1, 5'd0, 5'd0, 1, 1, 5'd7, 1, 0, 0); step("r0_lu", 2'b00, 2'b00, 0, 0, 0, 0, 5'd0);
        drain();

        // mul $8 with a dependent add right behind it
        d_in(1, 5'd1, 5'd2, 1, 1, 5'd8, 1, 0, 1); step("md_c0", 2'b00, 2'b00, 0, 0, 0, 0, 5'd0);
        d_in(1, 5'd8, 5'd9, 1, 1, 5'd10, 1, 0, 0); step("md_start", 2'b00, 2'b00, 1, 1, 0, 0, 5'd0);
                                                  step("md_busy4", 2'b00, 2'b00, 1, 0, 1, 0, 5'd8);
                                                  step("md_busy3", 2'b00, 2'b00, 1, 0, 1, 0, 5'd8);
                                                  step("md_busy2", 2'b00, 2'b00, 1, 0, 1, 0, 5'd8);
                                                  step("md_done", 2'b00, 2'b00, 1, 0, 1, 1, 5'd8);
                                                  step("md_free", 2'b00, 2'b00, 0, 0, 0, 0, 5'd8);
        d_nop();                                  step("md_after", 2'b00, 2'b00, 0, 0, 0, 0, 5'd8);
        drain();

        // independent work flows past a running mul, a later dependent waits
        d_in(1, 5'd1, 5'd2, 1, 1, 5'd8, 1, 0, 1);   step("mi_c0", 2'b00, 2'b00, 0, 0, 0, 0, 5'd8);
        d_in(1, 5'd1, 5'd2, 1, 1, 5'd10, 1, 0, 0);  step("mi_indep1", 2'b00, 2'b00, 0, 1, 0, 0, 5'd8);
        d_in(1, 5'd11, 5'd12, 1, 1, 5'd13, 1, 0, 0); step("mi_indep2", 2'b00, 2'b00, 0, 0, 1, 0, 5'd8);
        d_in(1, 5'd8, 5'd0, 1, 0, 5'd14, 1, 0, 0);  step("mi_dep3", 2'b00, 2'b00, 1, 0, 1, 0, 5'd8);
                                                    step("mi_dep2", 2'b00, 2'b00, 1, 0, 1, 0, 5'd8);
                                                    step("mi_done", 2'b00, 2'b00, 1, 0, 1, 1, 5'd8);
                                                    step("mi_free", 2'b00, 2'b00, 0, 0, 0, 0, 5'd8);
        drain();

        // flush in the load-use cycle suppresses the stall and kills the D op
        d_in(1, 5'd1, 5'd0, 1, 0, 5'd2, 1, 1, 0); step("fl_c0", 2'b00, 2'b00, 0, 0, 0, 0, 5'd8);
        d_in(1, 5'd2, 5'd0, 1, 0, 5'd9, 1, 0, 1);
        bus.flush = 1'b1;                         step("fl_stall", 2'b00, 2'b00, 0, 0, 0, 0, 5'd8);
        bus.flush = 1'b0;
        d_nop();                                  step("fl_kill", 2'b00, 2'b00, 0, 0, 0, 0, 5'd8);
        drain();

        // second mul stalls on busy; reset mid-op clears without md_done
        d_in(1, 5'd1, 5'd2, 1, 1, 5'd13, 1, 0, 1); step("rm_c0", 2'b00, 2'b00, 0, 0, 0, 0, 5'd8);
        d_nop();                                  step("rm_start", 2'b00, 2'b00, 0, 1, 0, 0, 5'd8);
        d_in(1, 5'd1, 5'd2, 1, 1, 5'd14, 1, 0, 1); step("md_md", 2'b00, 2'b00, 1, 0, 1, 0, 5'd13);
        d_nop();
        reset = 1'b0;                             step("rm_busy", 2'b00, 2'b00, 0, 0, 1, 0, 5'd13);
        reset = 1'b1;                             step("rm_clear", 2'b00, 2'b00, 0, 0, 0, 0, 5'd0);
                                                  step("rm_nodone1", 2'b00, 2'b00, 0, 0, 0, 0, 5'd0);
                                                  step("rm_nodone2", 2'b00, 2'b00, 0, 0, 0, 0, 5'd0);
        tick();
        check("sb_empty", 13'(vals.size()), 13'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/hazard_bypass_unit.md
Name: hazard_bypass_unit

Overview:
- Consumer of the 5-bit register-tag equality compare; owns all data-hazard decisions for the 5-stage pipeline (F/D/X/M/W).
- Tracks destination tags of in-flight instructions in a shadow pipeline (X, M, W).
- Drives bypass mux selects for the X-stage ALU operands.
- Raises stalls for load-use and multdiv-busy hazards; accepts branch flushes.

Parameters:
- MD_LATENCY, 32, cycles from md_start until the multdiv result is available (>=2).
- CNT_W, 6, width of the multdiv busy counter; must satisfy 2^CNT_W > MD_LATENCY.

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low; reset=0 at a rising edge clears all state.
- d_valid  in  1  D stage holds a real instruction.
- d_rs, d_rt  in  5 each  D-stage source register tags.
- d_rs_used, d_rt_used  in  1 each  source actually read.
- d_rd  in  5  D-stage destination tag.
- d_writes  in  1  D instruction writes d_rd.
- d_is_load  in  1  D instruction is a load.
- d_is_md  in  1  D instruction is a mult/div.
- flush  in  1  branch taken/mispredict resolved in X; kill D and X.
- byp_a_sel, byp_b_sel  out  2 each  X operand source: 00 regfile, 01 M result, 10 W result.
- stall  out  1  hold PC and F/D register; insert bubble into X.
- md_start  out  1  one-cycle pulse: multdiv op enters X.
- md_busy  out  1  multdiv unit occupied.
- md_done  out  1  one-cycle pulse: result valid, written at md_dest.
- md_dest  out  5  destination tag of the running multdiv.

Behaviour:
- Tag match rule: match(a,b) = (a==b) && (a!=0). $r0 never matches, so no bypass or stall is ever caused by $r0.
- Shadow entries X, M, W each hold {valid, dest[4:0], is_load}. X also holds {rs, rt, rs_used, rt_used, is_md}.
- Reset: all entries valid=0, counter=0, md_dest=0.
  - Outputs after reset: byp_*_sel=00, stall=0, md_start=0, md_busy=0, md_done=0.
- Each cycle: W<=M and M<=X, always.
- X update:
  - Normal: X<=D fields, with valid = d_valid & ~flush.
  - If stall=1 or flush=1: X<=bubble (valid=0).
  - An entry's valid feeds tag compares only when its writes bit is set. Store writes&valid as the entry valid.
- Bypass selects (combinational from X, M, W):
  - byp_a_sel=01 if X.rs_used & M.valid & match(X.rs,M.dest) & ~M.is_load.
  - Else 10 if X.rs_used & W.valid & match(X.rs,W.dest).
  - Else 00.
  - M has priority over W. A load in M is never bypassed from M (covered by the load-use stall).
  - byp_b_sel is identical using rt.
  - If X.valid=0, both selects = 00.
- Load-use stall: X.valid & X.is_load & ((d_rs_used & match(d_rs,X.dest)) | (d_rt_used & match(d_rt,X.dest))). Lasts exactly 1 cycle per load.
- Multdiv:
  - md_start = X.valid & X.is_md (registered entry, so it is a pulse).
  - On md_start: md_dest<=X.dest, counter<=MD_LATENCY, md_busy=1.
  - Counter decrements each cycle while >0. md_busy = (counter!=0).
  - md_done pulses in the cycle the counter goes 1->0.
- Multdiv stall: d_valid & md_busy & (d_is_md | (d_rs_used & match(d_rs,md_dest)) | (d_rt_used & match(d_rt,md_dest))).
  - The md_dest tag is still pending during the md_start cycle itself; include the X entry via the load-use-style check on X.is_md.
- stall = (load_use | md_stall) & ~flush. Flush wins over stall in the same cycle.
- flush does not abort a running multdiv (issued ops are committed).
- reset=0 mid-multdiv: counter cleared, no md_done pulse.
- Zero added latency: selects and stall are valid in the same cycle as the state they depend on.

Decomposition:
- Shared package: BYP_RF=2'b00, BYP_M=2'b01, BYP_W=2'b10; REG_ZERO=5'd0; tag width constant 5.
- Sub-module: reg_tag_match (5-bit equal with $r0 suppression), instantiated 8 times: 2 sources × {M, W} for bypass; 2 × X for load-use; 2 × md_dest for multdiv.
- Shadow entry struct {valid, dest, is_load} goes in the package.

Test Plan:
- add $3 then add $4,$3,$3 back-to-back -> next cycle byp_a_sel=01, byp_b_sel=01, stall=0.
- add $3; nop; sub $5,$3,$0 -> byp_a_sel=10, byp_b_sel=00.
- lw $2 then add $6,$2,$7 -> stall=1 for exactly 1 cycle; then the add sees byp_a_sel=10 (load in W).
- Writer to $0 then reader of $0 -> selects 00, stall=0. Load to $0 followed by a $0 reader -> no stall.
- mul $8 (MD_LATENCY=4) then add using $8:
  - md_start pulse, md_busy=1 for 4 cycles, stall held until md_done.
  - Independent instructions proceed, stall=0.
- lw $2 + dependent add with flush=1 in the stall cycle -> stall=0, X bubble. reset=0 mid-multdiv -> md_busy=0 next cycle, no md_done.
